// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl
//   Sequencer for the T-flip-flop counter datapath. Owns a WIDTH-bit up-counter
//   and runs it under a small FSM (IDLE, RUN, HOLD, DONE). It supports:
//     - start, pause/hold and abort
//     - terminal-count detection
//     - one-shot or auto-reload operation
//   A one-cycle done pulse is emitted on every terminal count.
//
//   Optional feature: define CNT_IRQ_STICKY_EN to add a sticky interrupt flag.
//   irq_o is set by each done pulse and cleared by irq_clr_i. If both happen
//   in the same cycle, the set wins.
//
// Parameters
//   WIDTH       counter / terminal-count width in bits (>= 1)
//   TC_DEFAULT  terminal-count register value after reset
//
// Ports
//   clk_i       rising-edge clock
//   reset_i     asynchronous, active-high reset
//   start_i     launch a count sequence (level, sampled in IDLE/DONE)
//   stop_i      abort the sequence and return to IDLE (highest priority)
//   hold_i      freeze the counter while high (RUN <-> HOLD)
//   mode_i      0 = one-shot, 1 = auto-reload; captured at start
//   load_en_i   write load_val_i into the terminal-count register (IDLE/DONE only)
//   load_val_i  new terminal count
//   count_o     current counter value
//   tc_o        current terminal-count register
//   busy_o      high in RUN or HOLD
//   done_o      one-cycle pulse per terminal count
//   irq_clr_i   (CNT_IRQ_STICKY_EN) clear the sticky interrupt
//   irq_o       (CNT_IRQ_STICKY_EN) sticky interrupt flag

module count_seq_ctrl #(
    parameter int unsigned      WIDTH      = 4,
    parameter logic [WIDTH-1:0] TC_DEFAULT = {WIDTH{1'b1}}
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             hold_i,
    input  logic             mode_i,
    input  logic             load_en_i,
    input  logic [WIDTH-1:0] load_val_i,
`ifdef CNT_IRQ_STICKY_EN
    input  logic             irq_clr_i,
    output logic             irq_o,
`endif
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] tc_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             at_tc;

    assign at_tc = (count_q == tc_q);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic (stop > start > hold > terminal count)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: begin
                if (stop_i) begin
                    state_d = StIdle;
                end else if (start_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (stop_i) begin
                    state_d = StIdle;
                end else if (hold_i) begin
                    state_d = StHold;
                end else if (at_tc && !mode_q) begin
                    state_d = StDone;
                end
            end
            StHold: begin
                if (stop_i) begin
                    state_d = StIdle;
                end else if (!hold_i) begin
                    // Resuming costs one cycle; the counter does not advance here.
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from the registered state
    // ------------------------------------------------------------------
    always_comb begin
        busy_o = 1'b0;
        case (state_q)
            StRun, StHold: busy_o = 1'b1;
            default:       busy_o = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state: counter, terminal count, captured mode, done
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        tc_d    = tc_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (load_en_i) begin
                    tc_d = load_val_i;
                end
                if (!stop_i && start_i) begin
                    count_d = '0;
                    mode_d  = mode_i;
                end
            end
            StRun: begin
                // stop and hold both leave the count untouched and suppress done.
                if (!stop_i && !hold_i) begin
                    if (at_tc) begin
                        done_d = 1'b1;
                        if (mode_q) begin
                            count_d = '0;
                        end
                    end else begin
                        count_d = count_q + WIDTH'(1'b1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
            tc_q    <= TC_DEFAULT;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign done_o  = done_q;

`ifdef CNT_IRQ_STICKY_EN
    logic irq_q, irq_d;

    // Set has priority over clear so a done pulse is never lost.
    always_comb begin
        irq_d = irq_q;
        if (irq_clr_i) begin
            irq_d = 1'b0;
        end
        if (done_d) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

endmodule
